mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: width of memory-side byte address.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_addr  input  ADDR_W  instruction fetch byte address.
REQ-005 i_oe  input  1  instruction read request, one-cycle strobe.
REQ-006 i_rdata  output  32  fetched instruction, held between completions.
REQ-007 i_ready  output  1  one-cycle pulse, i_rdata valid for the completed fetch.
REQ-008 d_addr  input  32  data byte address; only bits [ADDR_W-1:0] are used.
REQ-009 d_oe  input  1  data access request, one-cycle strobe.
REQ-010 d_we  input  4  byte write enables; 0000 means read.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data, held between completions.
REQ-013 d_ready  output  1  one-cycle pulse, data access completed.
REQ-014 m_addr / m_en / m_we[4] / m_wdata[32]  outputs  single-port synchronous RAM command.
REQ-015 m_rdata  input  32  RAM read data, valid one cycle after m_en with m_we==0.
REQ-016 conflict_cnt  output  32  count of instruction-deferral cycles (see REQ-036).

Function
REQ-017 Exactly one RAM command per cycle; m_addr, m_en, m_we and m_wdata are combinational from the granted source.
REQ-018 Priority: a new data request > a pending instruction request > a new instruction request.
REQ-019 d_oe at cycle N is always granted at N; d_ready pulses at N+1.
REQ-020 Data read: d_rdata loads m_rdata at N+1 and holds until the next data read completes.
REQ-021 Data write: d_we drives m_we at N; d_ready still pulses at N+1; d_rdata is unchanged.
REQ-022 i_oe at N with no d_oe and no pending fetch: granted at N; i_ready at N+1; i_rdata loads m_rdata.
REQ-023 i_oe and d_oe both at N: data granted; fetch latched (address into pend_addr, pend=1).
REQ-024 Pending fetch is granted in the first cycle with d_oe low; pend clears in that cycle; i_ready follows one cycle later.
REQ-025 i_rdata holds the last completed fetch until the next i_ready; it is never disturbed by data traffic.
REQ-026 In-flight tag register takes one of IDLE, INST or DATA and records the source granted last cycle; it steers m_rdata and the ready pulses.
REQ-027 Back-to-back requests on consecutive cycles are fully pipelined, one per cycle, with no bubble.
REQ-028 Requester rule: no new i_oe while a fetch is pending or in flight; a violating i_oe is ignored. The bench flags it as an error.
REQ-029 Data requests issued every cycle starve a pending fetch indefinitely; this is accepted, because the core cannot issue data without fetching.
REQ-030 When the RAM is idle, m_en=0 and m_we=0000.

Reset
REQ-031 Asynchronous assertion clears: pend=0, tag=IDLE, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, conflict_cnt=0.
REQ-032 Any access in flight or pending at reset is dropped; no ready pulse is produced for it after reset.
REQ-033 While rst=1, m_en=0 and m_we=0000.
REQ-034 The first request is accepted in the first cycle after rst deasserts.

Configuration
REQ-035 Macro MEM_ARBITER_STATS_EN selects the statistics feature.
REQ-036 With the macro defined: conflict_cnt increments by 1 in each cycle where a fetch is pending or deferred and not granted. It wraps from 0xFFFFFFFF to 0.
REQ-037 Without the macro: conflict_cnt is tied to 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-038 Idle fetch: i_oe at N, i_addr=0x0010, RAM[0x10]=0x00000013 -> i_ready=1 at N+1 with i_rdata=0x00000013; m_en=1 only at N.
REQ-039 Collision: i_oe and d_oe (read 0x0100) at N -> m_addr=0x0100 at N, 0x0010 at N+1; d_ready at N+1; i_ready at N+2; conflict_cnt=1 (STATS_EN).
REQ-040 Starvation then release: fetch pending, d_oe high N..N+3 -> fetch granted N+4, i_ready N+5; conflict_cnt=4 (STATS_EN) or 0 (no macro).
REQ-041 Store then load: d_oe with d_we=1111, addr 0x0200, wdata 0xDEADBEEF at N; read of 0x0200 at N+1 -> d_rdata=0xDEADBEEF at N+2; i_rdata unchanged throughout.
REQ-042 Reset mid-operation: fetch pending and a data read in flight, rst pulsed asynchronously mid-cycle -> all outputs 0 immediately; no i_ready/d_ready afterwards; a new fetch after release completes normally.
REQ-043 Hold check: i_ready at N, then 20 cycles of data reads -> i_rdata constant across all 20 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single-port synchronous RAM.
// Define MEM_ARBITER_STATS_EN to build the instruction-deferral counter behind conflict_cnt.
module mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_oe,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic [31:0]       d_addr,
    input  logic              d_oe,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic [31:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        TAG_IDLE = 2'd0,
        TAG_INST = 2'd1,
        TAG_DATA = 2'd2
    } tag_e;

    tag_e              tag_r;
    tag_e              tag_next_s;
    logic              pend_r;
    logic              pend_next_s;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [ADDR_W-1:0] pend_addr_next_s;
    logic              d_read_r;
    logic [31:0]       i_hold_r;
    logic [31:0]       d_hold_r;
    logic              i_new_s;
    logic              cmd_en_s;
    logic [3:0]        cmd_we_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [31:0]       cmd_wdata_s;
    logic              unused_s;

    // Only one fetch may be outstanding; a new i_oe while one is pending is dropped.
    assign i_new_s  = i_oe && !pend_r;
    assign unused_s = ^d_addr[31:ADDR_W];

    // Grant selection: new data > pending fetch > new fetch.
    always_comb begin
        tag_next_s       = TAG_IDLE;
        pend_next_s      = pend_r;
        pend_addr_next_s = pend_addr_r;
        cmd_en_s         = 1'b0;
        cmd_we_s         = 4'b0000;
        cmd_addr_s       = {ADDR_W{1'b0}};
        cmd_wdata_s      = 32'h0000_0000;
        if (d_oe) begin
            tag_next_s  = TAG_DATA;
            cmd_en_s    = 1'b1;
            cmd_we_s    = d_we;
            cmd_addr_s  = d_addr[ADDR_W-1:0];
            cmd_wdata_s = d_wdata;
            if (i_new_s) begin
                pend_next_s      = 1'b1;
                pend_addr_next_s = i_addr;
            end else begin
                pend_next_s      = pend_r;
            end
        end else if (pend_r) begin
            tag_next_s  = TAG_INST;
            pend_next_s = 1'b0;
            cmd_en_s    = 1'b1;
            cmd_addr_s  = pend_addr_r;
        end else if (i_new_s) begin
            tag_next_s  = TAG_INST;
            cmd_en_s    = 1'b1;
            cmd_addr_s  = i_addr;
        end else begin
            tag_next_s  = TAG_IDLE;
        end
    end

    // The RAM must see no command while reset is held, even mid-cycle.
    assign m_en    = cmd_en_s && !rst;
    assign m_we    = rst ? 4'b0000 : cmd_we_s;
    assign m_addr  = cmd_addr_s;
    assign m_wdata = cmd_wdata_s;

    // In-flight tag, pending fetch and the held read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r       <= TAG_IDLE;
            pend_r      <= 1'b0;
            pend_addr_r <= {ADDR_W{1'b0}};
            d_read_r    <= 1'b0;
            i_hold_r    <= 32'h0000_0000;
            d_hold_r    <= 32'h0000_0000;
        end else begin
            tag_r       <= tag_next_s;
            pend_r      <= pend_next_s;
            pend_addr_r <= pend_addr_next_s;
            d_read_r    <= d_oe && (d_we == 4'b0000);
            if (tag_r == TAG_INST) begin
                i_hold_r <= m_rdata;
            end
            if ((tag_r == TAG_DATA) && d_read_r) begin
                d_hold_r <= m_rdata;
            end
        end
    end

    // RAM data arrives in the completion cycle, so it is forwarded directly then and held afterwards.
    assign i_ready = (tag_r == TAG_INST);
    assign d_ready = (tag_r == TAG_DATA);
    assign i_rdata = (tag_r == TAG_INST) ? m_rdata : i_hold_r;
    assign d_rdata = ((tag_r == TAG_DATA) && d_read_r) ? m_rdata : d_hold_r;

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] conflict_cnt_r;
    logic        defer_s;

    assign defer_s = d_oe && (pend_r || i_new_s);

    // Counts every cycle a fetch waits behind a data access; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_r <= 32'h0000_0000;
        end else if (defer_s) begin
            conflict_cnt_r <= conflict_cnt_r + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`else
    assign conflict_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected completions,
// a negedge monitor pops and compares them and checks that read data holds in between.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_addr;
    logic        i_oe;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic [31:0] d_addr;
    logic        d_oe;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [15:0] m_addr;
    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [31:0] conflict_cnt;

`ifdef MEM_ARBITER_STATS_EN
    localparam logic STATS_ON = 1'b1;
`else
    localparam logic STATS_ON = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        i_q[$];
    exp_t        d_q[$];
    exp_t        mi;
    exp_t        md;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] i_hold = 32'h0;
    logic [31:0] d_hold = 32'h0;
    logic [31:0] mem [0:255];

    mem_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_oe(i_oe), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_addr(d_addr), .d_oe(d_oe), .d_we(d_we), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_addr(m_addr), .m_en(m_en), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model, preloaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h04] <= 32'h0000_0013;
            mem[8'h08] <= 32'hA0A0_A0A0;
            mem[8'h40] <= 32'h1111_1111;
            mem[8'h41] <= 32'h2222_2222;
            mem[8'h42] <= 32'h3333_3333;
            mem[8'h43] <= 32'h4444_4444;
            mem[8'h80] <= 32'h0000_0000;
        end else if (m_en) begin
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            if (m_we == 4'b0000) m_rdata <= mem[m_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] n);
        return STATS_ON ? n : 32'd0;
    endfunction

    task automatic drv(input logic io, input logic [15:0] ia, input logic dx,
                       input logic [31:0] da, input logic [3:0] dw, input logic [31:0] wd);
        i_oe = io; i_addr = ia; d_oe = dx; d_addr = da; d_we = dw; d_wdata = wd;
    endtask

    task automatic idle;
        drv(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input int c, input logic [31:0] v);
        i_q.push_back('{cyc: c, data: v});
    endtask

    task automatic push_d(input int c, input logic [31:0] v);
        d_q.push_back('{cyc: c, data: v});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_i_ready"}, {31'b0, i_ready}, 32'd0);
        chk({tag, "_d_ready"}, {31'b0, d_ready}, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_conflict_cnt"}, conflict_cnt, 32'd0);
        chk({tag, "_m_en"}, {31'b0, m_en}, 32'd0);
        chk({tag, "_m_we"}, {28'b0, m_we}, 32'd0);
    endtask

    // Monitor: completions must match the scoreboard; read data must hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_i_ready", {31'b0, i_ready}, 32'd0);
            chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
            i_hold = 32'h0;
            d_hold = 32'h0;
        end else begin
            if (i_ready) begin
                if (i_q.size() == 0) begin
                    chk("spurious_i_ready", 32'd1, 32'd0);
                end else begin
                    mi = i_q.pop_front();
                    chk("i_ready_cycle", cyc, mi.cyc);
                    chk("i_rdata", i_rdata, mi.data);
                    i_hold = mi.data;
                end
            end else begin
                chk("i_rdata_hold", i_rdata, i_hold);
            end
            if (d_ready) begin
                if (d_q.size() == 0) begin
                    chk("spurious_d_ready", 32'd1, 32'd0);
                end else begin
                    md = d_q.pop_front();
                    chk("d_ready_cycle", cyc, md.cyc);
                    chk("d_rdata", d_rdata, md.data);
                    d_hold = md.data;
                end
            end else begin
                chk("d_rdata_hold", d_rdata, d_hold);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) tick();
        chk_reset_state("reset");

        // Idle fetch accepted in the first cycle after reset release
        rst = 1'b0;
        drv(1'b1, 16'h0010, 1'b0, 32'h0, 4'h0, 32'h0);
        push_i(cyc + 1, 32'h0000_0013);
        #2;
        chk("fetch_m_en", {31'b0, m_en}, 32'd1);
        chk("fetch_m_addr", {16'b0, m_addr}, 32'h0010);
        tick(); idle(); #2;
        chk("idle_m_en", {31'b0, m_en}, 32'd0);
        chk("idle_m_we", {28'b0, m_we}, 32'd0);

        // Collision: data first, fetch one cycle later
        tick();
        drv(1'b1, 16'h0010, 1'b1, 32'h0000_0100, 4'h0, 32'h0);
        push_d(cyc + 1, 32'h1111_1111);
        push_i(cyc + 2, 32'h0000_0013);
        #2;
        chk("collide_m_addr_n", {16'b0, m_addr}, 32'h0100);
        tick(); idle(); #2;
        chk("collide_m_addr_n1", {16'b0, m_addr}, 32'h0010);
        chk("collide_m_en_n1", {31'b0, m_en}, 32'd1);
        tick(); tick();
        chk("collide_conflict", conflict_cnt, cnt_exp(32'd1));

        // Starvation: fetch deferred behind four back-to-back data reads
        tick();
        drv(1'b1, 16'h0020, 1'b1, 32'h0000_0104, 4'h0, 32'h0);
        push_d(cyc + 1, 32'h2222_2222);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0108, 4'h0, 32'h0);
        push_d(cyc + 1, 32'h3333_3333);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_010C, 4'h0, 32'h0);
        push_d(cyc + 1, 32'h4444_4444);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0100, 4'h0, 32'h0);
        push_d(cyc + 1, 32'h1111_1111);
        #2;
        chk("starve_m_addr_data", {16'b0, m_addr}, 32'h0100);
        tick(); idle();
        push_i(cyc + 1, 32'hA0A0_A0A0);
        #2;
        chk("release_m_addr", {16'b0, m_addr}, 32'h0020);
        chk("release_m_en", {31'b0, m_en}, 32'd1);
        tick(); tick();
        chk("starve_conflict", conflict_cnt, cnt_exp(32'd5));

        // Store then load, including a partial-byte store
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0200, 4'hF, 32'hDEAD_BEEF);
        push_d(cyc + 1, 32'h1111_1111);
        #2;
        chk("store_m_we", {28'b0, m_we}, 32'h0000_000F);
        chk("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0200, 4'h0, 32'h0);
        push_d(cyc + 1, 32'hDEAD_BEEF);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0200, 4'h3, 32'h1234_5678);
        push_d(cyc + 1, 32'hDEAD_BEEF);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0200, 4'h0, 32'h0);
        push_d(cyc + 1, 32'hDEAD_5678);
        tick(); idle();

        // Hold: one fetch followed by 20 pipelined data reads
        tick();
        drv(1'b1, 16'h0010, 1'b0, 32'h0, 4'h0, 32'h0);
        push_i(cyc + 1, 32'h0000_0013);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k[0]) begin
                drv(1'b0, 16'h0, 1'b1, 32'h0000_0104, 4'h0, 32'h0);
                push_d(cyc + 1, 32'h2222_2222);
            end else begin
                drv(1'b0, 16'h0, 1'b1, 32'h0000_0100, 4'h0, 32'h0);
                push_d(cyc + 1, 32'h1111_1111);
            end
        end
        tick(); idle();
        tick(); tick();

        // Reset mid-cycle with a fetch pending and a data read in flight
        drv(1'b1, 16'h0020, 1'b1, 32'h0000_0104, 4'h0, 32'h0);
        tick();
        drv(1'b0, 16'h0, 1'b1, 32'h0000_0108, 4'h0, 32'h0);
        #2;
        rst = 1'b1;
        idle();
        #1;
        chk_reset_state("midrst");
        tick(); tick();
        rst = 1'b0;
        drv(1'b1, 16'h0010, 1'b0, 32'h0, 4'h0, 32'h0);
        push_i(cyc + 1, 32'h0000_0013);
        tick(); idle();
        repeat (4) tick();
        chk("post_rst_conflict", conflict_cnt, 32'd0);

        chk("i_queue_drained", i_q.size(), 32'd0);
        chk("d_queue_drained", d_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
